mem_bram_sdp: RTL and testbench

Single-clock simple dual-port block RAM with per-lane write enables, selectable read latency, defined read/write collision behaviour and a built-in clear engine that zeroes the array after reset or on command. It is the next-generation storage primitive for the ping-pong frame buffers: one write port and one read port, both in the same clock domain, with `o_ready`/`o_rvalid` so clients never consume undefined contents.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_bram_core.sv | 48 ++++
 rtl/mem_bram_sdp.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bram_sdp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the block-RAM family: collision modes, controller
// state encoding and the lane-width helper used to slice write-enable lanes.
package mem_pkg;

  localparam int COLL_READ_FIRST  = 0;
  localparam int COLL_WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } bram_state_e;

  // Bits covered by one write-enable lane.
  function automatic int lane_width(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/mem_bram_core.sv
// Inferable simple dual-port storage: per-lane synchronous write and a
// registered read port with enable. A read of the address being written in
// the same cycle returns the old word.
module mem_bram_core
  import mem_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 153600,
  parameter int LANES = 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [LANES-1:0] wbe,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int LW = lane_width(WIDTH, LANES);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Write each enabled lane; disabled lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we && wbe[k]) begin
        mem_r[waddr][k*LW +: LW] <= wdata[k*LW +: LW];
      end
    end
  end

  // Registered read port; holds its value when no read is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_bram_sdp.sv
// Single-clock simple dual-port RAM with lane write enables, 1- or 2-cycle
// read latency, selectable collision behaviour and a zeroing clear engine.
// The top owns the clear FSM, range checks, collision forwarding and the
// read-valid pipeline; the storage itself lives in mem_bram_core.
module mem_bram_sdp
  import mem_pkg::*;
#(
  parameter int BRAM_WIDTH     = 12,
  parameter int BRAM_DEPTH     = 153600,
  parameter int LANES          = 1,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_wen,
  input  logic [LANES-1:0]              i_wbe,
  input  logic [$clog2(BRAM_DEPTH)-1:0] i_waddr,
  input  logic [BRAM_WIDTH-1:0]         i_wdata,
  input  logic                          i_ren,
  input  logic [$clog2(BRAM_DEPTH)-1:0] i_raddr,
  output logic [BRAM_WIDTH-1:0]         o_rdata,
  output logic                          o_rvalid,
  output logic                          o_ready
);

  localparam int AW = $clog2(BRAM_DEPTH);
  localparam int LW = lane_width(BRAM_WIDTH, LANES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
  localparam bram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  bram_state_e state_r, state_next_s;
  logic [AW-1:0] clr_cnt_r;
  logic ready_r;

  logic core_we_s;
  logic [LANES-1:0] core_wbe_s;
  logic [AW-1:0] core_waddr_s;
  logic [BRAM_WIDTH-1:0] core_wdata_s;
  logic [BRAM_WIDTH-1:0] core_rdata_s;

  logic wr_in_range_s, rd_in_range_s, user_wr_s, user_rd_s, coll_s;
  logic [BRAM_WIDTH-1:0] wmask_s;

  logic rd_v1_r, oor1_r, coll1_r;
  logic [BRAM_WIDTH-1:0] fwd_data1_r, fwd_mask1_r;
  logic [BRAM_WIDTH-1:0] rdata1_s;

  // User accesses are only honoured once the array is known to be initialised.
  assign wr_in_range_s = (32'(i_waddr) < 32'(BRAM_DEPTH));
  assign rd_in_range_s = (32'(i_raddr) < 32'(BRAM_DEPTH));
  assign user_wr_s = ready_r & i_wen & wr_in_range_s;
  assign user_rd_s = ready_r & i_ren;
  assign coll_s = user_wr_s & user_rd_s & (i_waddr == i_raddr);

  // Expand lane enables to a bit mask for write-first forwarding.
  always_comb begin
    wmask_s = {BRAM_WIDTH{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      wmask_s[k*LW +: LW] = {LW{i_wbe[k]}};
    end
  end

  // State register and clear address counter (counter idles at zero when ready).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= RESET_STATE;
      clr_cnt_r <= {AW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_CLEAR) && (clr_cnt_r != LAST_ADDR)) begin
        clr_cnt_r <= clr_cnt_r + AW'(1'b1);
      end else begin
        clr_cnt_r <= {AW{1'b0}};
      end
    end
  end

  // Next-state logic: clear sweeps once over the array, then serve users.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) state_next_s = ST_READY;
        else                        state_next_s = ST_CLEAR;
      end
      ST_READY: begin
        if (i_clear && ready_r) state_next_s = ST_CLEAR;
        else                    state_next_s = ST_READY;
      end
      default: state_next_s = RESET_STATE;
    endcase
  end

  // Write-port steering: the clear engine owns the port while clearing.
  always_comb begin
    core_we_s    = 1'b0;
    core_wbe_s   = {LANES{1'b0}};
    core_waddr_s = i_waddr;
    core_wdata_s = i_wdata;
    case (state_r)
      ST_CLEAR: begin
        core_we_s    = 1'b1;
        core_wbe_s   = {LANES{1'b1}};
        core_waddr_s = clr_cnt_r;
        core_wdata_s = {BRAM_WIDTH{1'b0}};
      end
      ST_READY: begin
        core_we_s  = user_wr_s;
        core_wbe_s = i_wbe;
      end
      default: begin
        core_we_s = 1'b0;
      end
    endcase
  end

  // Ready flag is registered so it reads low throughout reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state_next_s == ST_READY);
    end
  end

  mem_bram_core #(
    .WIDTH(BRAM_WIDTH),
    .DEPTH(BRAM_DEPTH),
    .LANES(LANES),
    .AW   (AW)
  ) u_core (
    .clk  (i_clk),
    .rst  (i_rst),
    .we   (core_we_s),
    .wbe  (core_wbe_s),
    .waddr(core_waddr_s),
    .wdata(core_wdata_s),
    .re   (user_rd_s & rd_in_range_s),
    .raddr(i_raddr),
    .rdata(core_rdata_s)
  );

  // First read stage: valid strobe plus range/collision side information,
  // captured only for accepted reads so the output holds between strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_v1_r     <= 1'b0;
      oor1_r      <= 1'b0;
      coll1_r     <= 1'b0;
      fwd_data1_r <= {BRAM_WIDTH{1'b0}};
      fwd_mask1_r <= {BRAM_WIDTH{1'b0}};
    end else begin
      rd_v1_r <= user_rd_s;
      if (user_rd_s) begin
        oor1_r      <= ~rd_in_range_s;
        coll1_r     <= coll_s;
        fwd_data1_r <= i_wdata;
        fwd_mask1_r <= wmask_s;
      end
    end
  end

  // Read data select: zero for out-of-range, lane-merged on write-first collision.
  always_comb begin
    if (oor1_r) begin
      rdata1_s = {BRAM_WIDTH{1'b0}};
    end else if ((COLLISION_MODE == COLL_WRITE_FIRST) && coll1_r) begin
      rdata1_s = (core_rdata_s & ~fwd_mask1_r) | (fwd_data1_r & fwd_mask1_r);
    end else begin
      rdata1_s = core_rdata_s;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [BRAM_WIDTH-1:0] rdata2_r;
      logic rvalid2_r;

      // Second read stage for the two-cycle latency option.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rdata2_r  <= {BRAM_WIDTH{1'b0}};
          rvalid2_r <= 1'b0;
        end else begin
          rvalid2_r <= rd_v1_r;
          if (rd_v1_r) begin
            rdata2_r <= rdata1_s;
          end
        end
      end

      assign o_rdata  = rdata2_r;
      assign o_rvalid = rvalid2_r;
    end else begin : g_lat1
      assign o_rdata  = rdata1_s;
      assign o_rvalid = rd_v1_r;
    end
  endgenerate

  assign o_ready = ready_r;

endmodule

// File: tb/tb_mem_bram_sdp.sv
// Directed bench for mem_bram_sdp (16-bit words, 12 deep, 2 lanes).
// dut_a: latency 1, read-first. dut_b: latency 2, write-first.
// dut_c: no clear on reset (only its ready timing is checked).
module tb_mem_bram_sdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wen;
  logic [1:0]  wbe;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        ren;
  logic [3:0]  raddr;

  logic [15:0] a_rdata, b_rdata, c_rdata;
  logic        a_rvalid, b_rvalid, c_rvalid;
  logic        a_ready, b_ready, c_ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_mem [12];

  always #5 clk = ~clk;

  mem_bram_sdp #(.BRAM_WIDTH(16), .BRAM_DEPTH(12), .LANES(2), .READ_LATENCY(1),
                 .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wen(wen), .i_wbe(wbe),
    .i_waddr(waddr), .i_wdata(wdata), .i_ren(ren), .i_raddr(raddr),
    .o_rdata(a_rdata), .o_rvalid(a_rvalid), .o_ready(a_ready));

  mem_bram_sdp #(.BRAM_WIDTH(16), .BRAM_DEPTH(12), .LANES(2), .READ_LATENCY(2),
                 .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wen(wen), .i_wbe(wbe),
    .i_waddr(waddr), .i_wdata(wdata), .i_ren(ren), .i_raddr(raddr),
    .o_rdata(b_rdata), .o_rvalid(b_rvalid), .o_ready(b_ready));

  mem_bram_sdp #(.BRAM_WIDTH(16), .BRAM_DEPTH(12), .LANES(2), .READ_LATENCY(1),
                 .COLLISION_MODE(1), .CLEAR_ON_RESET(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_wen(wen), .i_wbe(wbe),
    .i_waddr(waddr), .i_wdata(wdata), .i_ren(ren), .i_raddr(raddr),
    .o_rdata(c_rdata), .o_rvalid(c_rvalid), .o_ready(c_ready));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen   = 1'b0;
    ren   = 1'b0;
    clear = 1'b0;
    wbe   = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    waddr = 4'd0; raddr = 4'd0; wdata = 16'h0000;
    cyc(); cyc();
    checks++;
    if ({a_ready, b_ready, c_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got=%b exp=000", {a_ready, b_ready, c_ready});
    end
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid got=%b exp=00", {a_rvalid, b_rvalid});
    end
    checks++;
    if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata a=%h b=%h exp=0000", a_rdata, b_rdata);
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++;
      if (a_ready !== (i == 12) || b_ready !== (i == 12)) begin
        errors++; $display("FAIL clear_ready cycle=%0d a=%b b=%b exp=%b", i, a_ready, b_ready, (i == 12));
      end
      checks++;
      if (c_ready !== 1'b1) begin
        errors++; $display("FAIL noclear_ready cycle=%0d got=%b exp=1", i, c_ready);
      end
    end
    for (int ad = 0; ad < 12; ad++) begin
      exp_mem[ad] = 16'h0000;
      ren = 1'b1; raddr = 4'(ad);
      cyc();
      ren = 1'b0;
      checks++;
      if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000 || b_rvalid !== 1'b0) begin
        errors++; $display("FAIL init_read_lat1 addr=%0d a_v=%b a_d=%h b_v=%b exp 1/0000/0", ad, a_rvalid, a_rdata, b_rvalid);
      end
      cyc();
      checks++;
      if (b_rvalid !== 1'b1 || b_rdata !== 16'h0000 || a_rvalid !== 1'b0) begin
        errors++; $display("FAIL init_read_lat2 addr=%0d b_v=%b b_d=%h a_v=%b exp 1/0000/0", ad, b_rvalid, b_rdata, a_rvalid);
      end
    end
  endtask

  task automatic test_lane_write();
    wen = 1'b1; wbe = 2'b11; waddr = 4'd5; wdata = 16'hABCD;
    cyc();
    wbe = 2'b10; wdata = 16'h12EE;
    cyc();
    idle(); ren = 1'b1; raddr = 4'd5;
    cyc();
    ren = 1'b0;
    checks++;
    if (a_rdata !== 16'h12CD || a_rvalid !== 1'b1) begin
      errors++; $display("FAIL lane_write_a got=%h v=%b exp=12cd", a_rdata, a_rvalid);
    end
    cyc();
    checks++;
    if (b_rdata !== 16'h12CD || b_rvalid !== 1'b1) begin
      errors++; $display("FAIL lane_write_b got=%h v=%b exp=12cd", b_rdata, b_rvalid);
    end
    exp_mem[5] = 16'h12CD;
  endtask

  task automatic test_collision();
    wen = 1'b1; wbe = 2'b11; waddr = 4'd3; wdata = 16'h1111;
    cyc();
    wdata = 16'h5555; ren = 1'b1; raddr = 4'd3;
    cyc();
    idle();
    checks++;
    if (a_rdata !== 16'h1111) begin
      errors++; $display("FAIL coll_read_first got=%h exp=1111", a_rdata);
    end
    cyc();
    checks++;
    if (b_rdata !== 16'h5555) begin
      errors++; $display("FAIL coll_write_first got=%h exp=5555", b_rdata);
    end
    ren = 1'b1; raddr = 4'd3;
    cyc();
    ren = 1'b0;
    checks++;
    if (a_rdata !== 16'h5555) begin
      errors++; $display("FAIL coll_after_a got=%h exp=5555", a_rdata);
    end
    cyc();
    checks++;
    if (b_rdata !== 16'h5555) begin
      errors++; $display("FAIL coll_after_b got=%h exp=5555", b_rdata);
    end
    wen = 1'b1; wbe = 2'b01; waddr = 4'd3; wdata = 16'h66AA; ren = 1'b1; raddr = 4'd3;
    cyc();
    idle();
    checks++;
    if (a_rdata !== 16'h5555) begin
      errors++; $display("FAIL coll_lane_read_first got=%h exp=5555", a_rdata);
    end
    cyc();
    checks++;
    if (b_rdata !== 16'h55AA) begin
      errors++; $display("FAIL coll_lane_write_first got=%h exp=55aa", b_rdata);
    end
    exp_mem[3] = 16'h55AA;
  endtask

  task automatic test_out_of_range();
    wen = 1'b1; wbe = 2'b11; waddr = 4'd12; wdata = 16'hDEAD;
    cyc();
    waddr = 4'd15; wdata = 16'hBEEF;
    cyc();
    idle(); ren = 1'b1; raddr = 4'd12;
    cyc();
    ren = 1'b0;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000) begin
      errors++; $display("FAIL oor_read_a v=%b d=%h exp 1/0000", a_rvalid, a_rdata);
    end
    cyc();
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'h0000) begin
      errors++; $display("FAIL oor_read_b v=%b d=%h exp 1/0000", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 13; c++) begin
      if (c < 12) begin
        ren = 1'b1; raddr = 4'(c);
      end else begin
        ren = 1'b0;
      end
      cyc();
      checks++;
      if (a_rvalid !== (c < 12) || (c < 12 && a_rdata !== exp_mem[c])) begin
        errors++; $display("FAIL b2b_a step=%0d v=%b d=%h exp_v=%b", c, a_rvalid, a_rdata, (c < 12));
      end
      checks++;
      if (b_rvalid !== (c >= 1 && c <= 12) || (c >= 1 && c <= 12 && b_rdata !== exp_mem[c-1])) begin
        errors++; $display("FAIL b2b_b step=%0d v=%b d=%h exp_v=%b", c, b_rvalid, b_rdata, (c >= 1 && c <= 12));
      end
    end
    idle();
  endtask

  task automatic test_clear();
    wen = 1'b1; wbe = 2'b11; waddr = 4'd7; wdata = 16'h7777;
    cyc();
    waddr = 4'd0; wdata = 16'h0F0F;
    cyc();
    idle(); ren = 1'b1; raddr = 4'd0; clear = 1'b1;
    cyc();
    clear = 1'b0; raddr = 4'd7;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0F0F || a_ready !== 1'b0) begin
      errors++; $display("FAIL clear_inflight_a v=%b d=%h rdy=%b exp 1/0f0f/0", a_rvalid, a_rdata, a_ready);
    end
    cyc();
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'h0F0F || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL clear_inflight_b v=%b d=%h a_v=%b exp 1/0f0f/0", b_rvalid, b_rdata, a_rvalid);
    end
    for (int i = 2; i <= 12; i++) begin
      cyc();
      checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_ready !== (i == 12)) begin
        errors++; $display("FAIL clear_busy cycle=%0d a_v=%b b_v=%b rdy=%b exp 0/0/%b", i, a_rvalid, b_rvalid, a_ready, (i == 12));
      end
    end
    ren = 1'b0;
    for (int ad = 0; ad < 12; ad++) exp_mem[ad] = 16'h0000;
    ren = 1'b1; raddr = 4'd7;
    cyc();
    ren = 1'b0;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000) begin
      errors++; $display("FAIL cleared_a v=%b d=%h exp 1/0000", a_rvalid, a_rdata);
    end
    cyc();
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'h0000) begin
      errors++; $display("FAIL cleared_b v=%b d=%h exp 1/0000", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_reset_mid_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL midclear_rst_ready a=%b b=%b exp 0", a_ready, b_ready);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++;
      if (a_ready !== (i == 12) || b_ready !== (i == 12) || c_ready !== 1'b1) begin
        errors++; $display("FAIL midclear_restart cycle=%0d a=%b b=%b c=%b exp %b/%b/1", i, a_ready, b_ready, c_ready, (i == 12), (i == 12));
      end
    end
  endtask

  task automatic test_flush();
    ren = 1'b1; raddr = 4'd5;
    cyc();
    ren = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL flush_rvalid a=%b b=%b exp 0", a_rvalid, b_rvalid);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      checks++;
      if (b_rvalid !== 1'b0 || b_ready !== (i == 12)) begin
        errors++; $display("FAIL flush_after cycle=%0d v=%b rdy=%b exp 0/%b", i, b_rvalid, b_ready, (i == 12));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lane_write();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
